// File: rtl/des_pkg.sv
//------------------------------------------------------------------------------
// Module : des_pkg
// Brief  : Shared DES constants, IP/FP tables and serializer state type.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package des_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int DES_HALF_W  = 32;

    // Final permutation (IP^-1): output bit i takes preoutput bit FP_TABLE[i].
    localparam int FP_TABLE [1:64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int IP_TABLE [1:64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/fp_permutation.sv
//------------------------------------------------------------------------------
// Module : fp_permutation
// Brief  : Combinational DES final permutation, bit 1 = MSB.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp_permutation
    import des_pkg::*;
(
    input  logic [1:DES_BLOCK_W] data_i,
    output logic [1:DES_BLOCK_W] data_o
);

    genvar i;
    generate
        for (i = 1; i <= DES_BLOCK_W; i++) begin : g_bit
            assign data_o[i] = data_i[FP_TABLE[i]];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/des_fp_serializer.sv
//------------------------------------------------------------------------------
// Module : des_fp_serializer
// Brief  : DES output stage: half swap, final permutation, MSB-first beat stream.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module des_fp_serializer
    import des_pkg::*;
#(
    parameter int OUT_W       = 8,
    parameter int SWAP_HALVES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:DES_HALF_W]  l_i,
    input  logic [1:DES_HALF_W]  r_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [1:OUT_W]       data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o,
    output logic                 busy_o
);

    localparam int N     = DES_BLOCK_W / OUT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    logic [1:DES_BLOCK_W] pre;
    logic [1:DES_BLOCK_W] fp_out;
    logic [1:DES_BLOCK_W] shreg;
    logic [CNT_W-1:0]     cnt;
    ser_state_t           state;
    logic                 valid_q;
    logic                 last_q;
    logic                 busy_q;
    logic                 accept;

    generate
        if (SWAP_HALVES != 0) begin : g_swap
            assign pre = {r_i, l_i};
        end else begin : g_no_swap
            assign pre = {l_i, r_i};
        end
    endgenerate

    fp_permutation u_fp (
        .data_i (pre),
        .data_o (fp_out)
    );

    // Accepting during the final beat keeps the stream gap-free.
    assign ready_o = (state == ST_IDLE) || ((state == ST_SEND) && last_q && ready_i);
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (accept) begin
            state   <= ST_SEND;
            shreg   <= fp_out;
            cnt     <= '0;
            valid_q <= 1'b1;
            last_q  <= (LAST_CNT == '0);
            busy_q  <= 1'b1;
        end else if ((state == ST_SEND) && ready_i) begin
            if (last_q) begin
                state   <= ST_IDLE;
                shreg   <= '0;
                cnt     <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                shreg   <= shreg << OUT_W;
                cnt     <= cnt + CNT_W'(1);
                last_q  <= ((cnt + CNT_W'(1)) == LAST_CNT);
            end
        end
    end

    assign data_o  = shreg[1:OUT_W];
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_des_fp_serializer.sv
//------------------------------------------------------------------------------
// Module : tb_des_fp_serializer
// Brief  : Directed known-answer bench for des_fp_serializer (8- and 64-bit beats).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_des_fp_serializer;
    import des_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:32] l8, r8, l64, r64;
    logic        v8, rdy8, vo8, ri8, last8, busy8;
    logic        v64, rdy64, vo64, ri64, last64, busy64;
    logic [1:8]  d8;
    logic [1:64] d64;

    des_fp_serializer #(.OUT_W(8), .SWAP_HALVES(1)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .l_i(l8), .r_i(r8), .valid_i(v8), .ready_o(rdy8),
        .data_o(d8), .valid_o(vo8), .ready_i(ri8), .last_o(last8), .busy_o(busy8)
    );

    des_fp_serializer #(.OUT_W(64), .SWAP_HALVES(1)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .l_i(l64), .r_i(r64), .valid_i(v64), .ready_o(rdy64),
        .data_o(d64), .valid_o(vo64), .ready_i(ri64), .last_o(last64), .busy_o(busy64)
    );

    int n_pass  = 0;
    int n_total = 0;

    int fp_ref [1:64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam logic [63:0] KA_EXP  = 64'h85E813540F0AB405;
    localparam logic [63:0] INV_EXP = 64'h0123456789ABCDEF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send8(input string tag, input logic [31:0] l, input logic [31:0] r,
                         input logic [63:0] exp);
        @(negedge clk);
        l8 = l; r8 = r; v8 = 1'b1; ri8 = 1'b1;
        #1 check({tag, "_rdy"}, 64'(rdy8), 64'd1);
        @(posedge clk);
        #1 v8 = 1'b0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            check($sformatf("%s_d%0d", tag, b), 64'(d8), 64'(exp[63-8*b -: 8]));
            check($sformatf("%s_last%0d", tag, b), 64'(last8), 64'(b == 7));
            check($sformatf("%s_vld%0d", tag, b), 64'(vo8), 64'd1);
        end
        @(negedge clk);
        check({tag, "_idle_vld"}, 64'(vo8), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy8), 64'd0);
    endtask

    task automatic send64(input string tag, input logic [1:64] pre, input logic [63:0] exp);
        @(negedge clk);
        r64 = pre[1:32]; l64 = pre[33:64]; v64 = 1'b1; ri64 = 1'b1;
        @(posedge clk);
        #1 v64 = 1'b0;
        @(negedge clk);
        check({tag, "_d"}, d64, exp);
        check({tag, "_last"}, 64'(last64), 64'd1);
        check({tag, "_vld"}, 64'(vo64), 64'd1);
    endtask

    logic [1:64] pre_v, exp_v, x_v, ip_v;
    int b, c;

    initial begin
        rst = 1'b1;
        l8 = '0; r8 = '0; v8 = 1'b0; ri8 = 1'b0;
        l64 = '0; r64 = '0; v64 = 1'b0; ri64 = 1'b0;
        #12;
        check("rst_vld8", 64'(vo8), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_last8", 64'(last8), 64'd0);
        check("rst_d8", 64'(d8), 64'd0);
        check("rst_vld64", 64'(vo64), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_rdy8", 64'(rdy8), 64'd1);

        send8("ka", 32'h43423234, 32'h0A4CD995, KA_EXP);
        send8("onebit", 32'h01000000, 32'h0, 64'h8000000000000000);
        send8("inv8", 32'hF0AAF0AA, 32'hCC00CCFF, INV_EXP);

        // Backpressure: ready_i follows 1,0,0,1,...
        @(negedge clk);
        l8 = 32'h43423234; r8 = 32'h0A4CD995; v8 = 1'b1; ri8 = 1'b1;
        @(posedge clk);
        #1 v8 = 1'b0;
        b = 0; c = 0;
        while (b < 8 && c < 64) begin
            @(negedge clk);
            ri8 = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            check($sformatf("bp_d_c%0d", c), 64'(d8), 64'(KA_EXP[63-8*b -: 8]));
            check($sformatf("bp_last_c%0d", c), 64'(last8), 64'(b == 7));
            check($sformatf("bp_rdy_c%0d", c), 64'(rdy8), 64'((b == 7) && ri8));
            if (ri8) b++;
            c++;
        end
        check("bp_done", 64'(b), 64'd8);
        ri8 = 1'b1;
        @(negedge clk);
        check("bp_idle_vld", 64'(vo8), 64'd0);

        // Back-to-back: block 2 held on the inputs throughout block 1.
        @(negedge clk);
        l8 = 32'h43423234; r8 = 32'h0A4CD995; v8 = 1'b1; ri8 = 1'b1;
        @(posedge clk);
        #1 l8 = 32'hF0AAF0AA; r8 = 32'hCC00CCFF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("b2b1_d%0d", k), 64'(d8), 64'(KA_EXP[63-8*k -: 8]));
            check($sformatf("b2b1_rdy%0d", k), 64'(rdy8), 64'(k == 7));
        end
        @(posedge clk);
        #1 v8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("b2b2_vld%0d", k), 64'(vo8), 64'd1);
            check($sformatf("b2b2_d%0d", k), 64'(d8), 64'(INV_EXP[63-8*k -: 8]));
            check($sformatf("b2b2_last%0d", k), 64'(last8), 64'(k == 7));
        end
        @(negedge clk);
        check("b2b_idle_vld", 64'(vo8), 64'd0);

        // Reset in the middle of a block.
        @(negedge clk);
        l8 = 32'h43423234; r8 = 32'h0A4CD995; v8 = 1'b1; ri8 = 1'b1;
        @(posedge clk);
        #1 v8 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mid_d%0d", k), 64'(d8), 64'(KA_EXP[63-8*k -: 8]));
        end
        @(posedge clk);
        #1 check("mid_d4", 64'(d8), 64'(KA_EXP[31:24]));
        #1 rst = 1'b1;
        #1;
        check("mid_rst_vld", 64'(vo8), 64'd0);
        check("mid_rst_busy", 64'(busy8), 64'd0);
        check("mid_rst_last", 64'(last8), 64'd0);
        check("mid_rst_d", 64'(d8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("mid_rel_rdy", 64'(rdy8), 64'd1);
        send8("post_rst", 32'h43423234, 32'h0A4CD995, KA_EXP);

        // 64-bit beats: IP inverse known answer.
        send64("inv64", {32'hCC00CCFF, 32'hF0AAF0AA}, INV_EXP);
        @(negedge clk);
        check("inv64_idle_vld", 64'(vo64), 64'd0);

        // Walking one through every preoutput bit.
        for (int p = 1; p <= 64; p++) begin
            pre_v = '0;
            pre_v[p] = 1'b1;
            exp_v = '0;
            for (int i = 1; i <= 64; i++) if (fp_ref[i] == p) exp_v[i] = 1'b1;
            send64($sformatf("walk%0d", p), pre_v, exp_v);
        end

        // FP undoes the shared IP table.
        for (int k = 0; k < 4; k++) begin
            x_v = {$urandom(), $urandom()};
            for (int i = 1; i <= 64; i++) ip_v[i] = x_v[IP_TABLE[i]];
            send64($sformatf("ipfp%0d", k), ip_v, x_v);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/des_fp_serializer.md
Name: des_fp_serializer

Overview:
- Output stage of the DES datapath, the inverse end of the input IP permutation.
- Accepts the final round halves L16/R16 and optionally swaps them into the preoutput R16||L16.
- Applies the final permutation FP (IP^-1), holds the 64-bit result, and streams it out MSB-first in OUT_W-bit beats over a valid/ready handshake.
- Sits between the round pipeline and the byte-oriented output interface.

Parameters:
- OUT_W, 8, output beat width; legal values 8, 16, 32, 64 (must divide 64). Beats per block N = 64/OUT_W.
- SWAP_HALVES, 1, 1: preoutput = {r_i, l_i}; 0: preoutput = {l_i, r_i}, for callers that already swapped.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- l_i  in  [1:32]  L16, bit 1 = MSB.
- r_i  in  [1:32]  R16, bit 1 = MSB.
- valid_i  in  1  l_i/r_i valid.
- ready_o  out  1  block accepted when valid_i && ready_o.
- data_o  out  [1:OUT_W]  current output beat, bit 1 = MSB.
- valid_o  out  1  data_o valid.
- ready_i  in  1  downstream accepts beat when valid_o && ready_i.
- last_o  out  1  current beat is beat N-1 of the block.
- busy_o  out  1  a block is held (state SEND).

Behaviour:
- Reset (async assert, sync release): state IDLE, shift register 0, beat counter 0, valid_o=0, last_o=0, busy_o=0, data_o=0, ready_o=1 once out of reset.
- Preoutput pre[1:64] is selected per SWAP_HALVES.
- FP is combinational: out[i] = pre[T[i]]. T rows of 8, i = 1..64:
  - 40 8 48 16 56 24 64 32
  - 39 7 47 15 55 23 63 31
  - 38 6 46 14 54 22 62 30
  - 37 5 45 13 53 21 61 29
  - 36 4 44 12 52 20 60 28
  - 35 3 43 11 51 19 59 27
  - 34 2 42 10 50 18 58 26
  - 33 1 41 9 49 17 57 25
- FSM, two states:
  - IDLE: ready_o=1, valid_o=0. On valid_i, load FP(pre) into the 64-bit shift register, counter := 0, go to SEND.
  - SEND: valid_o=1, data_o = shreg[1:OUT_W], last_o = (counter == N-1). On ready_i with counter < N-1, shift left by OUT_W (zero fill) and increment counter. On ready_i with counter == N-1, go to IDLE, unless a new block is accepted in the same cycle.
- ready_o = IDLE || (SEND && last_o && ready_i). This combinational ready_i->ready_o path is intentional and gives full throughput.
- Simultaneous final-beat accept and new-block accept: reload the shift register, counter := 0, remain in SEND. valid_o stays high with no bubble.
- Stall (valid_o && !ready_i): data_o, last_o and counter hold stable.
- Latency: block accepted on edge k; first beat valid after edge k. Throughput is 1 block per N cycles with ready_i held high.
- valid_i while busy and not at the final accepted beat: ignored; the caller must hold the block.
- OUT_W=64: N=1, last_o is always 1 in SEND, and no shift occurs.
- Reset mid-block: the block is discarded immediately and all outputs return to reset values asynchronously.
- No X propagation: counter width is clog2(N) with a minimum of 1 bit.

Decomposition:
- des_pkg holds:
  - the FP_TABLE constant (64 entries, 1-based);
  - the shared IP table, so tests can check IP/FP inversion;
  - the DES_BLOCK_W = 64 and DES_HALF_W = 32 constants.
- One combinational sub-module, fp_permutation (data_i [1:64] -> data_o [1:64]), instantiated once. It is the mirror of the existing input permutation primitive.
- FSM, counter and shift register live in des_fp_serializer.

Test Plan:
- Known-answer, OUT_W=8, SWAP_HALVES=1: l_i=43423234, r_i=0A4CD995, ready_i=1 -> bytes 85 E8 13 54 0F 0A B4 05 on 8 consecutive cycles; last_o only on 05.
- IP inverse: l_i=F0AAF0AA, r_i=CC00CCFF, SWAP_HALVES=1, OUT_W=64 -> single beat 0123456789ABCDEF with last_o=1.
- Single-bit map: l_i=01000000, r_i=0, OUT_W=8 -> 80 00 00 00 00 00 00 00; walking a 1 through all 64 pre bits matches FP_TABLE.
- Backpressure: ready_i toggles 1,0,0,1,... during the known-answer block -> byte sequence unchanged; data_o stable while stalled; ready_o=0 until the final beat is accepted.
- Back-to-back: second block presented with valid_i held during the first; final beat 05 and the new block accepted in the same cycle -> next cycle data_o=first byte of block 2, valid_o never drops.
- Reset mid-block: assert rst_i after beat 3 -> valid_o, busy_o, last_o immediately 0, ready_o=1 after release; a new block then streams correctly from beat 0.
